// File: rtl/ray_pixel_scanner.sv
// Raster-order ray issuer and result collector for the ray-trace core.
// Issues one Pixel_s per cycle, tags it through a latency-matched delay line, and buffers results.

package ray_pixel_pkg;
    localparam int PIXEL_W = 12;

    typedef struct packed {
        logic signed [PIXEL_W-1:0] x;
        logic signed [PIXEL_W-1:0] y;
        logic signed [PIXEL_W-1:0] z;
    } Pixel_s;
endpackage

module ray_pixel_scanner
    import ray_pixel_pkg::*;
#(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int FOCAL_Z      = 31,
    parameter int CORE_LATENCY = 5,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       frame_done,
    output Pixel_s     pixel_o,
    input  logic       less_than_zero_i,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_col,
    output logic [8:0] out_row,
    output logic       out_hit
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [9:0] col;
        logic [8:0] row;
    } tag_t;

    typedef struct packed {
        logic [9:0] col;
        logic [8:0] row;
        logic       hit;
    } result_t;

    state_t           state_reg, state_next;
    logic [9:0]       col_reg, col_next;
    logic [8:0]       row_reg, row_next;
    Pixel_s           pixel_reg, pixel_next;
    logic [CNT_W-1:0] credits_reg, credits_next;

    logic issue;
    logic last_pixel;
    logic push;
    logic pop;
    logic line_empty;
    logic fifo_empty;

    // ------------------------------------------------------------------
    // Scan control
    // ------------------------------------------------------------------
    assign issue      = (state_reg == SCAN) && (credits_reg != '0);
    assign last_pixel = (col_reg == 10'(H_RES - 1)) && (row_reg == 9'(V_RES - 1));
    assign busy       = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        frame_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (issue && last_pixel) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // No tags in flight and nothing buffered: every result has been accepted.
                if (line_empty && fifo_empty) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        col_next   = col_reg;
        row_next   = row_reg;
        pixel_next = pixel_reg;
        if (state_reg == IDLE && start) begin
            col_next = '0;
            row_next = '0;
        end else if (issue) begin
            pixel_next.x = PIXEL_W'(col_reg) - PIXEL_W'(H_RES / 2);
            pixel_next.y = PIXEL_W'(V_RES / 2) - PIXEL_W'(row_reg);
            pixel_next.z = PIXEL_W'(FOCAL_Z);
            if (col_reg == 10'(H_RES - 1)) begin
                col_next = '0;
                row_next = (row_reg == 9'(V_RES - 1)) ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    // Each credit reserves one FIFO slot from issue until the result is popped.
    always_comb begin
        credits_next = credits_reg;
        case ({issue, pop})
            2'b10:   credits_next = credits_reg - 1'b1;
            2'b01:   credits_next = credits_reg + 1'b1;
            default: credits_next = credits_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            col_reg     <= '0;
            row_reg     <= '0;
            pixel_reg   <= '0;
            credits_reg <= CNT_W'(FIFO_DEPTH);
        end else begin
            state_reg   <= state_next;
            col_reg     <= col_next;
            row_reg     <= row_next;
            pixel_reg   <= pixel_next;
            credits_reg <= credits_next;
        end
    end

    assign pixel_o = pixel_reg;

    // ------------------------------------------------------------------
    // Tag delay line: stage 0 loads alongside pixel_reg, so the tag leaves
    // the last stage exactly CORE_LATENCY edges after the pixel changed.
    // ------------------------------------------------------------------
    tag_t [CORE_LATENCY:0]   tag_chain;
    logic [CORE_LATENCY-1:0] tag_valid;

    assign tag_chain[0] = {issue, col_reg, row_reg};

    genvar gi;
    generate
        for (gi = 0; gi < CORE_LATENCY; gi++) begin : g_stage
            tag_t stage_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= tag_chain[gi];
                end
            end

            assign tag_chain[gi+1] = stage_reg;
            assign tag_valid[gi]   = stage_reg.valid;
        end
    endgenerate

    assign line_empty = ~|tag_valid;
    assign push       = tag_chain[CORE_LATENCY].valid;

    // ------------------------------------------------------------------
    // Result FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    result_t          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    result_t          head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (count_reg == '0);
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {tag_chain[CORE_LATENCY].col, tag_chain[CORE_LATENCY].row,
                                     !less_than_zero_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_next;
        end
    end

    // Outputs read as zero while the FIFO is empty so stale entries never leak out.
    assign head    = fifo_mem[rd_ptr_reg];
    assign out_col = out_valid ? head.col : '0;
    assign out_row = out_valid ? head.row : '0;
    assign out_hit = out_valid ? head.hit : 1'b0;

    push_never_full : assert property (@(posedge clk) disable iff (rst)
        push |-> (count_reg != CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_ray_pixel_scanner.sv
// Randomized and directed bench for ray_pixel_scanner on a small 8x4 screen.
// Contains a latency-accurate core model and a raster-order result scoreboard.

module tb_ray_pixel_scanner;
    import ray_pixel_pkg::*;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int FZ    = 31;
    localparam int LAT   = 5;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       frame_done;
    Pixel_s     pixel_o;
    logic       ltz;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_col;
    logic [8:0] out_row;
    logic       out_hit;

    ray_pixel_scanner #(
        .H_RES(H), .V_RES(V), .FOCAL_Z(FZ), .CORE_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
        .pixel_o(pixel_o), .less_than_zero_i(ltz), .out_valid(out_valid),
        .out_ready(out_ready), .out_col(out_col), .out_row(out_row), .out_hit(out_hit)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Core model: miss decision per ray, result valid LAT-1 cycles after pixel_o changes.
    int core_mode  = 0;
    int ready_mode = 0;

    function automatic logic miss(input int x, input int y);
        case (core_mode)
            0:       return logic'(x == 2 - H / 2);
            1:       return logic'(!(x * x + y * y < 10));
            default: return logic'(((x * 5 + y * 3 + 7) & 2) != 0);
        endcase
    endfunction

    logic [LAT-2:0] core_pipe = '0;
    always @(posedge clk) core_pipe <= {core_pipe[LAT-3:0], miss(pixel_o.x, pixel_o.y)};
    assign ltz = core_pipe[LAT-2];

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard: expected results in raster order, built when a frame starts.
    typedef struct {
        int col;
        int row;
        int hit;
    } res_t;

    res_t   exp_q[$];
    res_t   cmp_r;
    int     pix_idx    = 0;
    int     done_count = 0;
    int     hits_seen  = 0;
    Pixel_s last_pix   = '0;
    logic   fd_prev    = 1'b0;
    logic   rst_q      = 1'b0;

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        if (rst_q) begin
            exp_q.delete();
            pix_idx  = 0;
            last_pix = pixel_o;
            fd_prev  = 1'b0;
        end else begin
            if (pixel_o != last_pix) begin
                check("pix_x", pixel_o.x, pix_idx % H - H / 2);
                check("pix_y", pixel_o.y, V / 2 - pix_idx / H);
                check("pix_z", pixel_o.z, FZ);
                pix_idx++;
                last_pix = pixel_o;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    cmp_r = exp_q.pop_front();
                    $display("[TB] result col=%0d row=%0d hit=%0d (exp %0d,%0d,%0d)",
                             out_col, out_row, out_hit, cmp_r.col, cmp_r.row, cmp_r.hit);
                    check("res_col", out_col, cmp_r.col);
                    check("res_row", out_row, cmp_r.row);
                    check("res_hit", out_hit, cmp_r.hit);
                    if (out_hit) hits_seen++;
                end
            end
            if (frame_done) begin
                check("fd_queue_empty", exp_q.size(), 0);
                check("fd_all_issued", pix_idx, H * V);
                check("fd_busy", busy, 1);
                check("fd_single_pulse", fd_prev, 0);
                done_count++;
                pix_idx = 0;
            end
            fd_prev = frame_done;
        end
    end

    int exp_done = 0;

    task automatic begin_frame();
        @(posedge clk);
        #1;
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                exp_q.push_back('{c, r, int'(!miss(c - H / 2, V / 2 - r))});
            end
        end
        exp_done++;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_frames(input int budget);
        int n = 0;
        while (done_count < exp_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_complete", done_count, exp_done);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int run;
        int ref_hits;

        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_col", out_col, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_hit", out_hit, 0);
        check("rst_pix_x", pixel_o.x, 0);
        check("rst_pix_z", pixel_o.z, 0);

        // Directed frame, steady ready: gapless stream, miss only at col 2.
        core_mode  = 0;
        ready_mode = 0;
        begin_frame();
        @(posedge clk);
        #1;
        check("lit_first_x", pixel_o.x, -4);
        check("lit_first_y", pixel_o.y, 2);
        check("lit_first_z", pixel_o.z, 31);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("lit_head_col", out_col, 0);
        check("lit_head_row", out_row, 0);
        check("lit_head_hit", out_hit, 1);
        run = 0;
        while (out_valid && run < 100) begin
            if (run == 2) check("lit_col2_miss", out_hit, 0);
            run++;
            @(negedge clk);
        end
        check("stream_gapless", run, H * V);
        wait_frames(500);
        @(negedge clk);
        check("idle_after_frame", busy, 0);

        // Stray starts during SCAN and DRAIN, then a start right after frame_done.
        core_mode = 2;
        begin_frame();
        repeat (5) @(posedge clk);
        #1;
        pulse_start();
        n = 0;
        while (pix_idx < H * V && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_busy", busy, 1);
        pulse_start();
        n = 0;
        while (!frame_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("fd_seen", frame_done, 1);
        begin_frame();
        @(posedge clk);
        #1;
        check("restart_col0_x", pixel_o.x, -4);
        check("restart_row0_y", pixel_o.y, 2);
        wait_frames(500);

        // Backpressure: issue stalls once every FIFO slot is reserved.
        core_mode  = 1;
        ready_mode = 3;
        begin_frame();
        repeat (30) @(negedge clk);
        check("stall_issued", pix_idx, DEPTH);
        check("stall_valid", out_valid, 1);
        check("stall_head_col", out_col, 0);
        ready_mode = 0;
        wait_frames(500);

        // Alternating ready with the circle core; hit total against direct count.
        ready_mode = 1;
        hits_seen  = 0;
        ref_hits   = 0;
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                if ((c - H / 2) * (c - H / 2) + (V / 2 - r) * (V / 2 - r) < 10) ref_hits++;
            end
        end
        begin_frame();
        wait_frames(500);
        check("circle_hits", hits_seen, ref_hits);

        // Random ready and random core pattern.
        core_mode  = 2;
        ready_mode = 2;
        for (int f = 0; f < 3; f++) begin
            begin_frame();
            wait_frames(800);
        end

        // Reset mid-SCAN with tags in flight and entries buffered.
        core_mode  = 1;
        ready_mode = 3;
        begin_frame();
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_pix_x", pixel_o.x, 0);
        check("abort_pix_y", pixel_o.y, 0);
        check("abort_pix_z", pixel_o.z, 0);
        exp_done--;
        run = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid || frame_done) run++;
        end
        check("abort_quiet", run, 0);
        check("abort_no_done", done_count, exp_done);
        ready_mode = 0;
        begin_frame();
        wait_frames(500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ray_pixel_scanner.md
Name: ray_pixel_scanner

Overview:
- Upstream driver and downstream collector for the ray-trace core.
- Walks the screen in raster order and presents one camera-space Pixel_s ray direction per issue cycle to the core's pixel input.
- Tags each issued ray with its screen coordinates through a delay line matched to the core latency.
- Pairs each tag with the core's less_than_zero result and hands (col, row, hit) to the framebuffer writer over a valid/ready interface.
- Buffers results in a credit-controlled FIFO, because the core itself cannot stall.

Parameters:
- H_RES, 640, columns per frame.
- V_RES, 480, rows per frame.
- FOCAL_Z, 31, constant pixel.z (image-plane distance).
- CORE_LATENCY, 5, cycles from a pixel input change to the matching less_than_zero.
- FIFO_DEPTH, 8, result FIFO entries; must be at least CORE_LATENCY+1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high while a frame is in SCAN or DRAIN
- frame_done  out  1  one-cycle pulse when the last result of a frame has been accepted
- pixel_o  out  Pixel_s  ray direction to the core; world is supplied to the core externally
- less_than_zero_i  in  1  core result (discriminant < 0, i.e. miss)
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_col  out  10  result column, 0..H_RES-1
- out_row  out  9  result row, 0..V_RES-1
- out_hit  out  1  1 = ray hits the sphere (inverse of less_than_zero_i)

Behaviour:
- Reset: state=IDLE; busy=0, frame_done=0, out_valid=0; out_col/out_row/out_hit=0; pixel_o={0,0,0}; col/row counters=0; delay line valids=0; FIFO empty; credits=FIFO_DEPTH.
- Reset mid-frame aborts the frame. No frame_done is produced, and in-flight core results are discarded.
- States:
  - IDLE: if start=1, go to SCAN next cycle with col=0, row=0.
  - SCAN: issue rays; after issuing col=H_RES-1, row=V_RES-1, go to DRAIN.
  - DRAIN: no issue; when the delay line and FIFO are both empty, pulse frame_done for one cycle and go to IDLE.
  - start is ignored outside IDLE.
- Issue condition: state==SCAN and credits>0.
- On issue:
  - pixel_o.x = col - H_RES/2, signed: -320..319.
  - pixel_o.y = V_RES/2 - row, signed: 240..-239.
  - pixel_o.z = FOCAL_Z.
  - All fields are registered, so the output is valid the cycle after the counter value.
  - col advances; at H_RES-1 it wraps to 0 and row advances.
- pixel_o holds its last issued value when not issuing.
- Delay line:
  - Shift register of {valid, col, row}.
  - Total offset from the pixel_o register update to FIFO write equals CORE_LATENCY.
  - Stage entry valid = issue.
  - When the tag emerges with valid=1, push {col, row, !less_than_zero_i} into the FIFO.
- Credits:
  - credits = FIFO_DEPTH - FIFO occupancy - in-flight valid tags.
  - Decrement on issue; increment on FIFO pop (out_valid & out_ready).
  - Issue and pop in the same cycle leave credits unchanged.
  - This guarantees a push never finds the FIFO full. Push while full is a design error and must be flagged by an assertion.
- FIFO:
  - First-word-fall-through; out_valid = not empty; outputs reflect the head entry.
  - Simultaneous push and pop allowed, including when occupancy is 1 (head updates next cycle) and when empty (a push becomes visible next cycle).
  - Order is strictly preserved.
- Throughput: with out_ready held at 1, one ray per cycle. Frame time = H_RES*V_RES + CORE_LATENCY + 2 cycles, give or take the FIFO output cycle.
- out_ready low: issue stops once credits reach 0; no result is lost or duplicated.
- busy = (state != IDLE).
- The frame_done cycle has busy=1; the following cycle is IDLE. start is accepted in the cycle after frame_done.

Test Plan:
- Directed full frame, H_RES=4, V_RES=2, out_ready=1, core model returning less_than_zero=1 for col==2 only -> 8 results in order (0,0)..(3,1), out_hit=0 exactly at col 2. pixel_o sequence: x=-2,-1,0,1 with y=1 then y=0; z=31. One frame_done pulse; busy=0 after.
- Backpressure: out_ready=0 from cycle 3 for 20 cycles -> exactly FIFO_DEPTH results buffered, issue stalls, credits=0. Release -> remaining results complete in order, none dropped or duplicated.
- Alternating out_ready (1,0,1,0) with the default 640x480 and a core model of x*x+y*y<10000 -> 307200 results. Hit count matches the reference count and each coordinate appears exactly once.
- start pulsed during SCAN and during DRAIN -> ignored, single frame. start in the cycle after frame_done -> new frame begins, col=0, row=0.
- rst asserted mid-SCAN with 3 tags in flight and 2 FIFO entries -> next cycle out_valid=0, busy=0, pixel_o=0, no frame_done. A subsequent start yields a clean full frame.
- Simultaneous push/pop with FIFO occupancy 1 and out_ready=1 steady -> out_valid stays high continuously, and the head advances each cycle.
